// File: rtl/data_mem_responder.sv
// Memory-side responder for the MOV/MOC handshake: programmable wait, big-endian byte-addressed RAM.
// Optional macro DATA_MEM_BUS_ERR_EN adds BusErr for accesses with address bits above ADDR_WIDTH set.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MOV,
  input  logic        R_W,
  input  logic [1:0]  DataSize,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MOC
`ifdef DATA_MEM_BUS_ERR_EN
  ,
  output logic        BusErr
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rw_q, rw_d;
  logic [1:0]              size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             dout_q, dout_d;
  logic                    moc_q, moc_d;
  logic                    mem_we_c;
  logic                    err_c;
  logic [ADDR_WIDTH-1:0]   base_c, a1_c, a2_c, a3_c;
  logic [31:0]             rdata_c;
  logic [7:0]              mem_q [DEPTH];

`ifdef DATA_MEM_BUS_ERR_EN
  logic oor_q, oor_d;
  logic berr_q, berr_d;
  assign err_c  = oor_q;
  assign BusErr = berr_q;
`else
  // Upper address bits wrap around and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Address[31:ADDR_WIDTH];
  assign err_c = 1'b0;
`endif

  assign DataOut = dout_q;
  assign MOC     = moc_q;

  // Aligned base address and the following byte lanes (big-endian order).
  always_comb begin
    case (size_q)
      2'b00:   base_c = addr_q;
      2'b01:   base_c = {addr_q[ADDR_WIDTH-1:1], 1'b0};
      default: base_c = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    endcase
    a1_c = base_c + ADDR_WIDTH'(1);
    a2_c = base_c + ADDR_WIDTH'(2);
    a3_c = base_c + ADDR_WIDTH'(3);
  end

  always_comb begin
    case (size_q)
      2'b00:   rdata_c = {24'b0, mem_q[base_c]};
      2'b01:   rdata_c = {16'b0, mem_q[base_c], mem_q[a1_c]};
      default: rdata_c = {mem_q[base_c], mem_q[a1_c], mem_q[a2_c], mem_q[a3_c]};
    endcase
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      case (size_q)
        2'b00: mem_q[base_c] <= wdata_q[7:0];
        2'b01: begin
          mem_q[base_c] <= wdata_q[15:8];
          mem_q[a1_c]   <= wdata_q[7:0];
        end
        default: begin
          mem_q[base_c] <= wdata_q[31:24];
          mem_q[a1_c]   <= wdata_q[23:16];
          mem_q[a2_c]   <= wdata_q[15:8];
          mem_q[a3_c]   <= wdata_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
`ifdef DATA_MEM_BUS_ERR_EN
      oor_q   <= 1'b0;
      berr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
`ifdef DATA_MEM_BUS_ERR_EN
      oor_q   <= oor_d;
      berr_q  <= berr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    moc_d    = moc_q;
    mem_we_c = 1'b0;
`ifdef DATA_MEM_BUS_ERR_EN
    oor_d    = oor_q;
    berr_d   = berr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (MOV) begin
          rw_d    = R_W;
          size_d  = DataSize;
          addr_d  = Address[ADDR_WIDTH-1:0];
          wdata_d = DataIn;
`ifdef DATA_MEM_BUS_ERR_EN
          oor_d   = |Address[31:ADDR_WIDTH];
`endif
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!MOV) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_d == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        moc_d   = 1'b1;
        state_d = S_RELEASE;
        if (err_c) begin
          dout_d = '0;
`ifdef DATA_MEM_BUS_ERR_EN
          berr_d = 1'b1;
`endif
        end else if (rw_q) begin
          dout_d = rdata_c;
        end else begin
          mem_we_c = 1'b1;
        end
      end
      S_RELEASE: begin
        // Four-phase: only a low MOV lets the FSM accept a new request.
        if (!MOV) begin
          moc_d   = 1'b0;
          state_d = S_IDLE;
`ifdef DATA_MEM_BUS_ERR_EN
          berr_d  = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: two instances (WAIT_CYCLES 2 and 0) checked
// against a byte-array reference model; honours DATA_MEM_BUS_ERR_EN when defined.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        mov_s  [2];
  logic        rw_s   [2];
  logic [1:0]  sz_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] din_s  [2];
  logic [31:0] dout_s [2];
  logic        moc_s  [2];
`ifdef DATA_MEM_BUS_ERR_EN
  logic        berr_s [2];
`endif

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  mem_m    [2][512];
  logic [31:0] exp_dout [2];

  data_mem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .MOV(mov_s[0]), .R_W(rw_s[0]), .DataSize(sz_s[0]),
    .Address(addr_s[0]), .DataIn(din_s[0]), .DataOut(dout_s[0]), .MOC(moc_s[0])
`ifdef DATA_MEM_BUS_ERR_EN
    , .BusErr(berr_s[0])
`endif
  );

  data_mem_responder #(.ADDR_WIDTH(9), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .MOV(mov_s[1]), .R_W(rw_s[1]), .DataSize(sz_s[1]),
    .Address(addr_s[1]), .DataIn(din_s[1]), .DataOut(dout_s[1]), .MOC(moc_s[1])
`ifdef DATA_MEM_BUS_ERR_EN
    , .BusErr(berr_s[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic int unsigned wait_of(input int sel);
    return (sel == 0) ? 2 : 0;
  endfunction

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int unsigned base_of(input logic [1:0] sz, input logic [31:0] addr);
    int unsigned b;
    b = addr % 512;
    return b - (b % nbytes(sz));
  endfunction

  function automatic logic [31:0] m_read(input int sel, input logic [1:0] sz, input logic [31:0] addr);
    logic [31:0] r;
    int unsigned b;
    r = 0;
    b = base_of(sz, addr);
    for (int i = 0; i < int'(nbytes(sz)); i++) r = (r << 8) | 32'(mem_m[sel][b + i]);
    return r;
  endfunction

  task automatic m_write(input int sel, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] d);
    int unsigned b, n;
    b = base_of(sz, addr);
    n = nbytes(sz);
    for (int i = 0; i < int'(n); i++) mem_m[sel][b + i] = 8'(d >> (8 * (int'(n) - 1 - i)));
  endtask

  // One full four-phase transaction; starts and ends just after a negedge with MOV low.
  task automatic op(input int sel, input logic rw, input logic [1:0] sz, input logic [31:0] addr,
                    input logic [31:0] din, input int hold, input string tag);
    logic err;
    int   lat;
    err = 1'b0;
`ifdef DATA_MEM_BUS_ERR_EN
    err = |addr[31:9];
`endif
    if (err) exp_dout[sel] = 32'h0;
    else if (rw) exp_dout[sel] = m_read(sel, sz, addr);
    else m_write(sel, sz, addr, din);

    rw_s[sel] = rw; sz_s[sel] = sz; addr_s[sel] = addr; din_s[sel] = din; mov_s[sel] = 1'b1;
    @(posedge clk);
    #1;
    rw_s[sel] = 1'($urandom); sz_s[sel] = 2'($urandom); addr_s[sel] = $urandom; din_s[sel] = $urandom;

    lat = -1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (moc_s[sel] === 1'b1) begin
        lat = j;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(wait_of(sel) + 1));
    check({tag, "_dout"}, dout_s[sel], exp_dout[sel]);
`ifdef DATA_MEM_BUS_ERR_EN
    check({tag, "_buserr"}, 32'(berr_s[sel]), 32'(err));
`endif

    // While MOV stays high a fresh write request must be ignored.
    for (int h = 0; h < hold; h++) begin
      rw_s[sel] = 1'b0; sz_s[sel] = 2'b10; addr_s[sel] = addr; din_s[sel] = ~din;
      @(negedge clk);
      check({tag, "_hold_moc"}, 32'(moc_s[sel]), 32'd1);
    end

    mov_s[sel] = 1'b0;
    @(negedge clk);
    check({tag, "_release_moc"}, 32'(moc_s[sel]), 32'd0);
`ifdef DATA_MEM_BUS_ERR_EN
    check({tag, "_release_buserr"}, 32'(berr_s[sel]), 32'd0);
`endif
  endtask

  initial begin
    logic        seen;
    logic [31:0] a;
    logic [31:0] hi;

    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      mov_s[s] = 1'b0; rw_s[s] = 1'b0; sz_s[s] = 2'b00; addr_s[s] = 0; din_s[s] = 0;
      exp_dout[s] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_moc", 32'(moc_s[s]), 32'd0);
      check("reset_dout", dout_s[s], 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Word write then word/byte reads.
    op(0, 1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 0, "w_write");
    op(0, 1'b1, 2'b10, 32'h10, 32'h0, 0, "w_read");
    check("w_read_const", dout_s[0], 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) op(0, 1'b1, 2'b00, 32'(32'h10 + i), 32'h0, 0, "b_read");
    check("b_read_last_const", dout_s[0], 32'h000000EF);

    // Known contents for both memories below 0x80.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 32; i++)
        if (!(s == 0 && i == 4)) op(s, 1'b0, 2'b10, 32'(4 * i), $urandom, 0, "prefill");

    op(0, 1'b0, 2'b00, 32'h21, 32'h123456AA, 0, "strb");
    op(0, 1'b1, 2'b10, 32'h20, 32'h0, 0, "strb_wread");
    check("strb_byte21", 32'(dout_s[0][23:16]), 32'hAA);
    op(0, 1'b1, 2'b01, 32'h23, 32'h0, 0, "half_read_masked");

    // Hold MOV after MOC, with a competing request presented meanwhile.
    op(0, 1'b1, 2'b10, 32'h40, 32'h0, 5, "hold");
    op(0, 1'b1, 2'b10, 32'h40, 32'h0, 0, "no_back_to_back");

    // Abort in WAIT.
    rw_s[0] = 1'b0; sz_s[0] = 2'b00; addr_s[0] = 32'h30; din_s[0] = {24'h0, ~mem_m[0][32'h30]};
    mov_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mov_s[0] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (moc_s[0] !== 1'b0) seen = 1'b1;
    end
    check("abort_moc", 32'(seen), 32'd0);
    op(0, 1'b1, 2'b00, 32'h30, 32'h0, 0, "abort_readback");

    // Asynchronous reset while waiting.
    op(0, 1'b1, 2'b10, 32'h10, 32'h0, 0, "pre_reset_read");
    rw_s[0] = 1'b0; sz_s[0] = 2'b10; addr_s[0] = 32'h34; din_s[0] = ~m_read(0, 2'b10, 32'h34);
    mov_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_dout[0] = 0;
    exp_dout[1] = 0;
    check("async_reset_moc", 32'(moc_s[0]), 32'd0);
    check("async_reset_dout", dout_s[0], 32'd0);
    check("async_reset_dout_w0", dout_s[1], 32'd0);
    mov_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    op(0, 1'b1, 2'b10, 32'h34, 32'h0, 0, "post_reset_read");

    // Upper address bits: wrap by default, bus error when enabled.
    op(0, 1'b0, 2'b10, 32'h0000_0210, 32'h0BADF00D, 0, "hi_addr_write");
    op(0, 1'b1, 2'b10, 32'h10, 32'h0, 0, "hi_addr_readback");
    op(0, 1'b1, 2'b10, 32'h8000_0010, 32'h0, 0, "hi_addr_read");

    // Zero-wait instance.
    op(1, 1'b0, 2'b10, 32'h10, 32'h01234567, 0, "w0_write");
    op(1, 1'b1, 2'b10, 32'h10, 32'h0, 0, "w0_read");
    check("w0_read_const", dout_s[1], 32'h01234567);
    op(1, 1'b1, 2'b01, 32'h13, 32'h0, 0, "w0_half");

    // Random traffic inside the known region, occasionally with upper address bits set.
    for (int k = 0; k < 60; k++) begin
      a  = 32'($urandom_range(0, 127));
      hi = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FE00) : 32'h0;
      op(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), hi | a, $urandom, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the control unit's MOV/MOC memory handshake.
- Accepts a read or write request qualified by MOV, waits a programmable number of cycles, performs a big-endian byte-addressed access, then asserts MOC.
- Sits between the datapath's MAR/MDR and the simulated RAM. Serves LDR/STR/LDRB/STRB microstates.

Parameters:
- ADDR_WIDTH, 9: byte-address bits used; depth = 2^ADDR_WIDTH bytes (512).
- WAIT_CYCLES, 2: cycles spent in WAIT before the access. Legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- MOV  input  1  memory operation valid from control unit; held high until MOC is seen.
- R_W  input  1  1 = read, 0 = write.
- DataSize  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- Address  input  32  byte address (from MAR).
- DataIn  input  32  write data (from MDR); byte uses [7:0], halfword uses [15:0].
- DataOut  output  32  read data, zero-extended.
- MOC  output  1  memory operation complete.

Behaviour:
- Reset (reset = 0, asynchronous):
  - FSM goes to IDLE; MOC = 0; DataOut = 0; wait counter = 0.
  - Memory contents are not cleared.
  - Reset mid-operation aborts with no write.
- FSM states: IDLE, WAIT, DONE, RELEASE.
- IDLE:
  - MOV = 1 at posedge → latch Address, R_W, DataSize and DataIn.
  - Load counter with WAIT_CYCLES, then go to WAIT.
  - If WAIT_CYCLES = 0, go directly to DONE.
- WAIT:
  - Counter decrements each cycle; at 0, go to DONE.
  - MOV = 0 in WAIT → abort to IDLE, no access, MOC stays 0.
- DONE (one cycle): perform the access using the latched values.
  - Write: update bytes on this edge.
  - Read: DataOut is registered on this edge.
  - MOC goes to 1 on the same edge. Go to RELEASE.
- RELEASE:
  - MOC held at 1 while MOV = 1.
  - MOV = 0 at posedge → MOC = 0 and return to IDLE.
  - A new request needs MOV low for at least one cycle (four-phase handshake).
- Latency: MOV sampled high at edge N → MOC high after edge N + WAIT_CYCLES + 1.
- Alignment:
  - Word forces addr[1:0] = 00; halfword forces addr[0] = 0.
  - Effective address = latched Address[ADDR_WIDTH-1:0] after masking.
- Big-endian layout:
  - Word byte at addr holds DataIn[31:24], addr+3 holds [7:0].
  - Halfword byte at addr holds [15:8].
- Reads:
  - Byte → {24'b0, mem[a]}.
  - Halfword → {16'b0, mem[a], mem[a+1]}.
  - Word → all four bytes.
- DataOut holds its last read value through writes and idle cycles.
- Address bits above ADDR_WIDTH are ignored (wrap) unless BUS_ERR_EN is defined.
- Input changes on Address, DataIn, R_W or DataSize after the request is latched have no effect.

Optional Feature:
- Macro: DATA_MEM_BUS_ERR_EN.
- Defined:
  - Adds output BusErr (1 bit); reset value 0.
  - If any latched Address bit [31:ADDR_WIDTH] is 1: no write occurs, DataOut = 0, and BusErr = 1 in DONE.
  - BusErr clears together with MOC.
  - Handshake timing is unchanged.
- Undefined: no BusErr port; upper address bits are ignored (wrap-around).

Test Plan:
- Reset, word write then read:
  - Reset low 2 cycles, release. Word write 0xDEADBEEF at 0x10 (WAIT_CYCLES = 2): MOC rises exactly 3 edges after MOV is sampled.
  - Word read at 0x10 → DataOut = 0xDEADBEEF. Byte reads 0x10..0x13 → 0xDE, 0xAD, 0xBE, 0xEF.
- Byte and halfword sizes:
  - STRB DataIn = 0x123456AA at 0x21, then word read at 0x20 → byte 0x21 = 0xAA, other bytes unchanged.
  - Halfword read at 0x23 → masked to 0x22.
- Four-phase handshake:
  - Hold MOV high 5 extra cycles after MOC → MOC stays 1.
  - Drop MOV → MOC = 0 on the next edge.
  - Back-to-back request without a MOV low cycle is not accepted.
- Abort and reset mid-operation:
  - Write 0x55 with MOV dropped during WAIT → memory unchanged, MOC never rises.
  - Assert reset asynchronously in WAIT → MOC = 0 and DataOut = 0 immediately; next request works normally.
- Wrap-around and bus error:
  - Address 0x0000_0210 write, read 0x10 → same data (macro undefined).
  - With DATA_MEM_BUS_ERR_EN defined → BusErr = 1 with MOC, DataOut = 0, no write.
- WAIT_CYCLES = 0 instance: MOC rises one edge after MOV is sampled; data correct.
